bus_transfer_sequencer: RTL and testbench

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

---
 rtl/bus_transfer_sequencer.sv | 65 ++++++
 tb/tb_bus_transfer_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: sequences one register-to-register bus transfer (drive, latch, hold, turnaround) per request.
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int LATCH_CYCLES = 1,
  localparam int SELW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SELW-1:0]     src_sel,
  input  logic [SELW-1:0]     dst_sel,
  output logic [NUM_REGS-1:0] oe_n,
  output logic [NUM_REGS-1:0] le,
  output logic                busy,
  output logic                done,
  output logic                err
);
  typedef enum logic [2:0] {IDLE, SETUP, LATCH, HOLD, TURN} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [SELW-1:0] src_q, dst_q, src_n, dst_n;
  logic acc, ok;
  assign req_ready = state == IDLE;
  always_comb begin
    acc = state == IDLE && req_valid;
    ok = src_sel != dst_sel && 32'(src_sel) < NUM_REGS && 32'(dst_sel) < NUM_REGS;
    state_n = state;
    case (state)
      IDLE:    state_n = acc && ok ? SETUP : IDLE;
      SETUP:   state_n = cnt == 2'(SETUP_CYCLES - 1) ? LATCH : SETUP;
      LATCH:   state_n = cnt == 2'(LATCH_CYCLES - 1) ? HOLD : LATCH;
      HOLD:    state_n = TURN;
      default: state_n = IDLE;
    endcase
    cnt_n = state_n != state ? '0 : cnt + 2'd1;
    src_n = acc && ok ? src_sel : src_q;
    dst_n = acc && ok ? dst_sel : dst_q;
  end
  // outputs are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      src_q <= '0;
      dst_q <= '0;
      oe_n <= '1;
      le <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      src_q <= src_n;
      dst_q <= dst_n;
      oe_n <= state_n inside {SETUP, LATCH, HOLD} ? ~(NUM_REGS'(1) << src_n) : '1;
      le <= state_n == LATCH ? NUM_REGS'(1) << dst_n : '0;
      busy <= state_n != IDLE;
      done <= state_n == TURN;
      err <= acc && !ok;
    end
  end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: three parameterisations driven by shared stimulus, checked against a schedule model.
module tb_bus_transfer_sequencer;
  localparam int NR[3] = '{4, 4, 3};
  localparam int SC[3] = '{1, 3, 2};
  localparam int LC[3] = '{1, 2, 1};
  logic clk = 1'b0, reset_n = 1'b0, req_valid = 1'b0;
  logic [1:0] src_sel = '0, dst_sel = '0;
  logic [3:0] o0, o1, l0, l1;
  logic [2:0] o2, l2;
  logic [2:0] rdy, bsy, dn, er;
  logic [3:0] oe_n [3], le [3];
  int checks = 0, errors = 0;
  int k [3];
  logic [1:0] ms [3], md [3];
  logic me [3];

  always #5 clk = ~clk;

  bus_transfer_sequencer #(.NUM_REGS(4), .SETUP_CYCLES(1), .LATCH_CYCLES(1)) u0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .src_sel(src_sel), .dst_sel(dst_sel), .oe_n(o0), .le(l0),
    .busy(bsy[0]), .done(dn[0]), .err(er[0]));
  bus_transfer_sequencer #(.NUM_REGS(4), .SETUP_CYCLES(3), .LATCH_CYCLES(2)) u1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .src_sel(src_sel), .dst_sel(dst_sel), .oe_n(o1), .le(l1),
    .busy(bsy[1]), .done(dn[1]), .err(er[1]));
  bus_transfer_sequencer #(.NUM_REGS(3), .SETUP_CYCLES(2), .LATCH_CYCLES(1)) u2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy[2]),
    .src_sel(src_sel), .dst_sel(dst_sel), .oe_n(o2), .le(l2),
    .busy(bsy[2]), .done(dn[2]), .err(er[2]));

  always_comb begin
    oe_n[0] = o0;
    oe_n[1] = o1;
    oe_n[2] = {1'b1, o2};
    le[0] = l0;
    le[1] = l1;
    le[2] = {1'b0, l2};
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic bit legal(input int i);
    return src_sel != dst_sel && int'(src_sel) < NR[i] && int'(dst_sel) < NR[i];
  endfunction

  // k counts cycles since the accepting edge; 0 means idle
  always @(posedge clk or negedge reset_n)
    for (int i = 0; i < 3; i++)
      if (!reset_n) begin
        k[i] <= 0;
        me[i] <= 1'b0;
      end else if (k[i] == 0) begin
        me[i] <= req_valid && !legal(i);
        if (req_valid && legal(i)) begin
          k[i] <= 1;
          ms[i] <= src_sel;
          md[i] <= dst_sel;
        end
      end else begin
        me[i] <= 1'b0;
        k[i] <= k[i] == SC[i] + LC[i] + 2 ? 0 : k[i] + 1;
      end

  function automatic logic [3:0] x_oe(input int i);
    return k[i] >= 1 && k[i] <= SC[i] + LC[i] + 1 ? ~(4'b1 << ms[i]) : 4'hf;
  endfunction

  function automatic logic [3:0] x_le(input int i);
    return k[i] > SC[i] && k[i] <= SC[i] + LC[i] ? 4'b1 << md[i] : 4'h0;
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("oe_n[%0d]", i), 32'(oe_n[i]), 32'(x_oe(i)));
      chk($sformatf("le[%0d]", i), 32'(le[i]), 32'(x_le(i)));
      chk($sformatf("req_ready[%0d]", i), 32'(rdy[i]), 32'(k[i] == 0));
      chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(k[i] != 0));
      chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(k[i] == SC[i] + LC[i] + 2));
      chk($sformatf("err[%0d]", i), 32'(er[i]), 32'(me[i]));
      chk($sformatf("one_oe[%0d]", i), 32'($countones(~oe_n[i]) <= 1), 32'd1);
      chk($sformatf("le_undriven[%0d]", i), 32'(le[i] != 0 && oe_n[i] == 4'hf), 32'd0);
    end

  task automatic wait_idle();
    for (int n = 0; n < 30 && !(&rdy); n++) @(negedge clk);
    chk("idle_timeout", 32'(&rdy), 32'd1);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d);
    req_valid = v;
    src_sel = s;
    dst_sel = d;
  endtask

  initial begin
    int run, oec, lec, dc, dcnt;
    int runs[$];
    repeat (2) @(negedge clk);
    chk("rst_oe_n", 32'(o0), 32'hf);
    chk("rst_le", 32'(l0), 32'h0);
    chk("rst_flags", 32'({bsy[0], dn[0], er[0]}), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdy[0]), 32'd1);

    drive(1, 2'd1, 2'd2);
    @(negedge clk);
    drive(0, 2'd1, 2'd2);
    chk("xfer_setup_oe", 32'(o0), 32'b1101);
    chk("xfer_setup_le", 32'(l0), 32'h0);
    @(negedge clk);
    chk("xfer_latch_le", 32'(l0), 32'b0100);
    chk("xfer_latch_oe", 32'(o0), 32'b1101);
    @(negedge clk);
    chk("xfer_hold_le", 32'(l0), 32'h0);
    chk("xfer_hold_oe", 32'(o0), 32'b1101);
    @(negedge clk);
    chk("xfer_turn_oe", 32'(o0), 32'hf);
    chk("xfer_turn_done", 32'(dn[0]), 32'd1);
    @(negedge clk);
    chk("xfer_ready", 32'(rdy[0]), 32'd1);
    wait_idle();

    drive(1, 2'd3, 2'd3);
    @(negedge clk);
    chk("rej_err", 32'(er[0]), 32'd1);
    chk("rej_oe", 32'(o0), 32'hf);
    chk("rej_le", 32'(l0), 32'h0);
    chk("rej_busy", 32'(bsy[0]), 32'd0);
    drive(1, 2'd0, 2'd1);
    @(negedge clk);
    drive(0, 2'd0, 2'd1);
    chk("rej_next_busy", 32'(bsy[0]), 32'd1);
    chk("rej_next_oe", 32'(o0), 32'b1110);
    wait_idle();

    drive(1, 2'd0, 2'd1);
    run = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bsy[0]) drive(1, 2'd2, 2'd0);
      if (bsy[0]) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
    drive(0, 2'd0, 2'd0);
    chk("b2b_runs", 32'(runs.size() >= 2), 32'd1);
    if (runs.size() >= 2) begin
      chk("b2b_run0", 32'(runs[0]), 32'd4);
      chk("b2b_run1", 32'(runs[1]), 32'd4);
    end
    wait_idle();

    drive(1, 2'd1, 2'd2);
    @(posedge clk);
    #1 drive(0, 2'd1, 2'd2);
    @(posedge clk);
    #1 chk("mid_in_latch", 32'(l0), 32'b0100);
    #1 reset_n = 1'b0;
    #1 chk("mid_rst_oe", 32'(o0), 32'hf);
    chk("mid_rst_le", 32'(l0), 32'h0);
    chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      dcnt += int'(dn[0]);
    end
    chk("mid_rst_no_done", 32'(dcnt), 32'd0);

    drive(1, 2'd1, 2'd2);
    oec = 0;
    lec = 0;
    dc = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) drive(0, 2'd1, 2'd2);
      oec += int'(!o1[1]);
      lec += int'(l1[2]);
      if (dn[1]) dc = c;
    end
    chk("p_oe_cycles", 32'(oec), 32'd6);
    chk("p_le_cycles", 32'(lec), 32'd2);
    chk("p_done_cycle", 32'(dc), 32'd7);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 199) == 0) begin
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    drive(0, 2'd0, 2'd0);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
